l1_cache_ctrl_assoc: RTL and testbench

- Parametrised successor to the single-way L1 controller: N-way set-associative, write-back, write-allocate L1 controller with multi-word line bursts to DRAM.
- Holds the tag, valid, dirty and replacement state internally in flops.
- Drives address and write controls of the external data SRAM and the word-serial DRAM interface.
- Sits between the CPU load/store stage and DRAM. One instance each for I-side and D-side.

---
 rtl/l1_cache_ctrl_assoc_pkg.sv | 35 +++
 rtl/l1_cache_ctrl_assoc_if.sv | 58 +++++
 rtl/l1_cache_ctrl_assoc_tag_array.sv | 102 ++++++++++
 rtl/l1_cache_ctrl_assoc.sv | 209 ++++++++++++++++++++
 tb/tb_l1_cache_ctrl_assoc.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_cache_ctrl_assoc_pkg.sv
// Shared definitions for the set-associative L1 controller: FSM states and address field widths.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package l1_cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        WB      = 2'd2,
        REFILL  = 2'd3
    } l1_state_e;

    // Default number of 32-bit beats in one line burst.
    localparam int L1_LINE_WORDS = 4;
    // Byte-offset bits below the word field.
    localparam int L1_BYTE_BITS  = 2;

    // A single-way build still carries a 1-bit way select.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
        return addr_w - L1_BYTE_BITS - word_bits(line_words) - idx_bits(sets);
    endfunction

endpackage

// File: rtl/l1_cache_ctrl_assoc_if.sv
// CPU, data-SRAM and DRAM signal bundle of the L1 controller (master = CPU/memory side, slave = controller).
// Latency: n/a (wires only).
// Backpressure: CPU held by stall until cpu_ack; DRAM beats paced by dram_ack.
interface l1_cache_ctrl_assoc_if
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = L1_LINE_WORDS
);
    localparam int WAY_W  = way_bits(WAYS);
    localparam int IDX_W  = idx_bits(SETS);
    localparam int WORD_W = word_bits(LINE_WORDS);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic              stall;
    logic [WAY_W-1:0]  sram_way;
    logic [IDX_W-1:0]  sram_index;
    logic [WORD_W-1:0] sram_word;
    logic              sram_we;
    logic              sram_data_sel;
    logic              dram_cs;
    logic              dram_we;
    logic [ADDR_W-1:0] dram_addr;
    logic              dram_ack;
`ifdef L1_PERF_CNT_EN
    logic [31:0]       perf_hits;
    logic [31:0]       perf_misses;
    logic [31:0]       perf_wbacks;

    modport master (
        output cpu_req, cpu_we, cpu_addr, dram_ack,
        input  cpu_ack, stall, sram_way, sram_index, sram_word, sram_we, sram_data_sel,
        input  dram_cs, dram_we, dram_addr, perf_hits, perf_misses, perf_wbacks
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, dram_ack,
        output cpu_ack, stall, sram_way, sram_index, sram_word, sram_we, sram_data_sel,
        output dram_cs, dram_we, dram_addr, perf_hits, perf_misses, perf_wbacks
    );
`else
    modport master (
        output cpu_req, cpu_we, cpu_addr, dram_ack,
        input  cpu_ack, stall, sram_way, sram_index, sram_word, sram_we, sram_data_sel,
        input  dram_cs, dram_we, dram_addr
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, dram_ack,
        output cpu_ack, stall, sram_way, sram_index, sram_word, sram_we, sram_data_sel,
        output dram_cs, dram_we, dram_addr
    );
`endif

endinterface

// File: rtl/l1_cache_ctrl_assoc_tag_array.sv
// Tag/valid/dirty flops per way plus per-set round-robin pointer; parallel hit detect and victim pick.
// Latency: lookup combinational from index/req_tag; updates take effect on the next clk edge.
// Backpressure: none; the controller sequences all updates.
// Ports: index/req_tag select the lookup; hit/hit_way, vic_* and all_valid describe the set;
//        set_dirty/clr_dirty/fill act on upd_way at index; fill_adv_rr steps rr_ptr on a fill.
module l1_tag_array
    import l1_cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 16,
    parameter int TAG_W = 24,
    parameter int WAY_W = way_bits(WAYS),
    parameter int IDX_W = idx_bits(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] req_tag,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] vic_way,
    output logic             vic_valid,
    output logic             vic_dirty,
    output logic [TAG_W-1:0] vic_tag,
    output logic             all_valid,
    input  logic [WAY_W-1:0] upd_way,
    input  logic             set_dirty,
    input  logic             clr_dirty,
    input  logic             fill,
    input  logic             fill_adv_rr
);
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [SETS-1:0]  valid_q [WAYS];
    logic [SETS-1:0]  dirty_q [WAYS];
    logic [WAY_W-1:0] rr_cur;
    logic             found_inv;

    // Lowest-index invalid way wins; only a fully valid set falls back to rr_ptr.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        all_valid = 1'b1;
        found_inv = 1'b0;
        vic_way   = rr_cur;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][index] && (tag_q[w][index] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[w][index]) begin
                all_valid = 1'b0;
                if (!found_inv) begin
                    found_inv = 1'b1;
                    vic_way   = WAY_W'(w);
                end
            end
        end
    end

    assign vic_valid = valid_q[vic_way][index];
    assign vic_dirty = dirty_q[vic_way][index];
    assign vic_tag   = tag_q[vic_way][index];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
                for (int s = 0; s < SETS; s++) begin
                    tag_q[w][s] <= '0;
                end
            end
        end else begin
            if (set_dirty) dirty_q[upd_way][index] <= 1'b1;
            if (clr_dirty) dirty_q[upd_way][index] <= 1'b0;
            if (fill) begin
                tag_q[upd_way][index]   <= req_tag;
                valid_q[upd_way][index] <= 1'b1;
                dirty_q[upd_way][index] <= 1'b0;
            end
        end
    end

    if (WAYS > 1) begin : g_rr
        logic [WAY_W-1:0] rr_q [SETS];

        // WAYS is a power of two, so the natural wrap of the counter is modulo WAYS.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
            end else if (fill && fill_adv_rr) begin
                rr_q[index] <= rr_q[index] + WAY_W'(1);
            end
        end
        assign rr_cur = rr_q[index];
    end else begin : g_no_rr
        logic unused_adv;
        assign rr_cur     = '0;
        assign unused_adv = fill_adv_rr;
    end

endmodule

// File: rtl/l1_cache_ctrl_assoc.sv
// N-way write-back/write-allocate L1 controller: FSM, beat counter and DRAM address mux around l1_tag_array.
// Latency: hit acks in the cycle after request; miss adds LINE_WORDS refill beats (plus LINE_WORDS WB beats if dirty).
// Backpressure: stall holds the CPU until cpu_ack; each DRAM beat waits indefinitely for dram_ack.
// Ports: clk, rst (async active-low), bus (slave side of l1_cache_ctrl_assoc_if).
// Optional: `define L1_PERF_CNT_EN adds saturating perf_hits/perf_misses/perf_wbacks counters.
module l1_cache_ctrl_assoc
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = L1_LINE_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    l1_cache_ctrl_assoc_if.slave   bus
);
    localparam int WAY_W  = way_bits(WAYS);
    localparam int WORD_W = word_bits(LINE_WORDS);
    localparam int IDX_W  = idx_bits(SETS);
    localparam int TAG_W  = tag_bits(ADDR_W, SETS, LINE_WORDS);

    l1_state_e         state_q, state_d;
    logic [ADDR_W-1:2] addr_q;
    logic              we_q;
    logic [WORD_W-1:0] beat_q;
    logic [WAY_W-1:0]  vic_way_q;
    logic [TAG_W-1:0]  vic_tag_q;
    logic              vic_all_q;

    logic              hit, vic_valid, vic_dirty, all_valid;
    logic [WAY_W-1:0]  hit_way, vic_way, upd_way;
    logic [TAG_W-1:0]  vic_tag;
    logic              cpu_ack, sram_we, set_dirty, clr_dirty, fill, miss_go, beat_inc;
    logic              last_beat;
    logic              unused_byte_bits;

    wire [WORD_W-1:0] req_word = addr_q[2 +: WORD_W];
    wire [IDX_W-1:0]  req_idx  = addr_q[2+WORD_W +: IDX_W];
    wire [TAG_W-1:0]  req_tag  = addr_q[ADDR_W-1 -: TAG_W];

    // Byte offset never reaches the SRAM or DRAM; transfers are whole words.
    assign unused_byte_bits = ^bus.cpu_addr[1:0];
    assign last_beat        = (beat_q == WORD_W'(LINE_WORDS - 1));
    // Dirty-set acts on the hit way; write-back clear and fill act on the latched victim.
    assign upd_way          = (state_q == COMPARE) ? hit_way : vic_way_q;

    l1_tag_array #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk         (clk),
        .rst         (rst),
        .index       (req_idx),
        .req_tag     (req_tag),
        .hit         (hit),
        .hit_way     (hit_way),
        .vic_way     (vic_way),
        .vic_valid   (vic_valid),
        .vic_dirty   (vic_dirty),
        .vic_tag     (vic_tag),
        .all_valid   (all_valid),
        .upd_way     (upd_way),
        .set_dirty   (set_dirty),
        .clr_dirty   (clr_dirty),
        .fill        (fill),
        .fill_adv_rr (fill & vic_all_q)
    );

    always_comb begin
        state_d   = state_q;
        cpu_ack   = 1'b0;
        sram_we   = 1'b0;
        set_dirty = 1'b0;
        clr_dirty = 1'b0;
        fill      = 1'b0;
        miss_go   = 1'b0;
        beat_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) state_d = COMPARE;
            end
            COMPARE: begin
                if (!bus.cpu_req) begin
                    state_d = IDLE;
                end else if (hit) begin
                    cpu_ack = 1'b1;
                    if (we_q) begin
                        sram_we   = 1'b1;
                        set_dirty = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    miss_go = 1'b1;
                    state_d = (vic_valid && vic_dirty) ? WB : REFILL;
                end
            end
            WB: begin
                if (bus.dram_ack) begin
                    beat_inc = 1'b1;
                    if (last_beat) begin
                        clr_dirty = 1'b1;
                        state_d   = REFILL;
                    end
                end
            end
            REFILL: begin
                if (bus.dram_ack) begin
                    sram_we  = 1'b1;
                    beat_inc = 1'b1;
                    if (last_beat) begin
                        fill    = 1'b1;
                        state_d = COMPARE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.sram_way      = '0;
        bus.sram_word     = '0;
        bus.sram_data_sel = 1'b0;
        bus.dram_cs       = 1'b0;
        bus.dram_we       = 1'b0;
        bus.dram_addr     = '0;
        case (state_q)
            COMPARE: begin
                bus.sram_way  = hit_way;
                bus.sram_word = req_word;
            end
            WB: begin
                bus.sram_way  = vic_way_q;
                bus.sram_word = beat_q;
                bus.dram_cs   = 1'b1;
                bus.dram_we   = 1'b1;
                bus.dram_addr = {vic_tag_q, req_idx, beat_q, 2'b00};
            end
            REFILL: begin
                bus.sram_way      = vic_way_q;
                bus.sram_word     = beat_q;
                bus.sram_data_sel = 1'b1;
                bus.dram_cs       = 1'b1;
                bus.dram_addr     = {req_tag, req_idx, beat_q, 2'b00};
            end
            default: ;
        endcase
    end

    assign bus.sram_index = req_idx;
    assign bus.cpu_ack    = cpu_ack;
    assign bus.sram_we    = sram_we;
    assign bus.stall      = bus.cpu_req & ~cpu_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            beat_q    <= '0;
            vic_way_q <= '0;
            vic_tag_q <= '0;
            vic_all_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.cpu_req) begin
                addr_q <= bus.cpu_addr[ADDR_W-1:2];
                we_q   <= bus.cpu_we;
            end
            // Victim is frozen at the miss so WB and REFILL agree even as valid bits change.
            if (miss_go) begin
                vic_way_q <= vic_way;
                vic_tag_q <= vic_tag;
                vic_all_q <= all_valid;
            end
            // Power-of-two line: the counter wraps back to 0 on the last beat.
            if (beat_inc) beat_q <= beat_q + WORD_W'(1);
        end
    end

`ifdef L1_PERF_CNT_EN
    logic [31:0] perf_hits_q, perf_misses_q, perf_wbacks_q;
    logic        from_refill_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
            perf_wbacks_q <= '0;
            from_refill_q <= 1'b0;
        end else begin
            // The completing hit after a refill belongs to the miss already counted.
            if (fill) from_refill_q <= 1'b1;
            else if (state_q == COMPARE) from_refill_q <= 1'b0;
            if (cpu_ack && !from_refill_q && perf_hits_q != '1) perf_hits_q <= perf_hits_q + 32'd1;
            if (miss_go && perf_misses_q != '1) perf_misses_q <= perf_misses_q + 32'd1;
            if (miss_go && vic_valid && vic_dirty && perf_wbacks_q != '1)
                perf_wbacks_q <= perf_wbacks_q + 32'd1;
        end
    end

    assign bus.perf_hits   = perf_hits_q;
    assign bus.perf_misses = perf_misses_q;
    assign bus.perf_wbacks = perf_wbacks_q;
`endif

endmodule

// File: tb/tb_l1_cache_ctrl_assoc.sv
// Directed bench for l1_cache_ctrl_assoc with default parameters and a DRAM beat responder.
// Latency: n/a.
// Backpressure: responder can stretch dram_ack by a configurable gap or stop acking.
module tb_l1_cache_ctrl_assoc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    l1_cache_ctrl_assoc_if bus ();

    l1_cache_ctrl_assoc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Responder control and beat log: {dram_we, sram_we, sram_data_sel, sram_word, dram_addr}.
    int          gap        = 0;
    int          ack_budget = -1;
    logic [36:0] q_beat[$];
    int          last_ack_cyc = 0;
    int          idle_cnt = 0;
    int          idle_bad = 0;
    logic [31:0] hold_addr;
    bit          hold_vld = 0;

    initial begin : dram_model
        int wait_cnt;
        wait_cnt     = 0;
        bus.dram_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst && bus.dram_cs && ack_budget != 0 && wait_cnt >= gap) begin
                bus.dram_ack = 1'b1;
                wait_cnt     = 0;
                if (ack_budget > 0) ack_budget--;
            end else begin
                bus.dram_ack = 1'b0;
                if (rst && bus.dram_cs) wait_cnt++;
                else wait_cnt = 0;
            end
            @(negedge clk);
            if (bus.dram_ack && bus.dram_cs) begin
                q_beat.push_back({bus.dram_we, bus.sram_we, bus.sram_data_sel, bus.sram_word, bus.dram_addr});
                last_ack_cyc = cyc;
                if (hold_vld && bus.dram_addr !== hold_addr) idle_bad++;
                hold_vld = 0;
            end else if (bus.dram_cs) begin
                idle_cnt++;
                if (bus.sram_we !== 1'b0) idle_bad++;
                if (hold_vld && bus.dram_addr !== hold_addr) idle_bad++;
                hold_addr = bus.dram_addr;
                hold_vld  = 1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Results of the most recent CPU access.
    bit          acc_got;
    int          acc_lat, acc_cyc;
    logic        acc_swe, acc_sel, acc_stall0;
    logic [0:0]  acc_way;

    task automatic clr_log();
        q_beat.delete();
        idle_cnt = 0;
        idle_bad = 0;
        hold_vld = 0;
    endtask

    task automatic cpu_access(input logic we, input logic [31:0] addr);
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = addr;
        acc_got = 0; acc_lat = 0; acc_cyc = 0;
        acc_swe = 1'b0; acc_sel = 1'b0; acc_way = 1'b0; acc_stall0 = 1'b0;
        for (int i = 0; i < 400 && !acc_got; i++) begin
            @(negedge clk);
            acc_lat++;
            if (i == 0) acc_stall0 = bus.stall;
            if (bus.cpu_ack === 1'b1) begin
                acc_got = 1;
                acc_cyc = cyc;
                acc_swe = bus.sram_we;
                acc_sel = bus.sram_data_sel;
                acc_way = bus.sram_way;
            end
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    task automatic test_reset();
        logic [45:0] outs;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {bus.cpu_ack, bus.stall, bus.sram_way, bus.sram_index, bus.sram_word, bus.sram_we,
                bus.sram_data_sel, bus.dram_cs, bus.dram_we, bus.dram_addr};
        checks++;
        if (outs !== 46'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
`ifdef L1_PERF_CNT_EN
        checks++;
        if ({bus.perf_hits, bus.perf_misses, bus.perf_wbacks} !== 96'd0) begin
            failures++;
            $display("FAIL reset_perf: got %h/%h/%h expected 0", bus.perf_hits, bus.perf_misses, bus.perf_wbacks);
        end
`endif
        rst = 1'b1;
    endtask

    task automatic test_cold_read();
        logic [36:0] exp;
        clr_log();
        cpu_access(1'b0, 32'h40);
        checks++;
        if (acc_got !== 1'b1 || acc_stall0 !== 1'b1) begin
            failures++;
            $display("FAIL cold_ack: got ack=%0d stall=%0d expected 1/1", acc_got, acc_stall0);
        end
        checks++;
        if (q_beat.size() != 4) begin
            failures++;
            $display("FAIL cold_beats: got %0d beats expected 4", q_beat.size());
        end
        for (int b = 0; b < q_beat.size() && b < 4; b++) begin
            exp = {1'b0, 1'b1, 1'b1, 2'(b), 32'h40 + 32'(4 * b)};
            checks++;
            if (q_beat[b] !== exp) begin
                failures++;
                $display("FAIL cold_beat%0d: got %h expected %h", b, q_beat[b], exp);
            end
        end
        checks++;
        if (acc_cyc - last_ack_cyc != 1 || acc_swe !== 1'b0) begin
            failures++;
            $display("FAIL cold_ack_timing: got delta=%0d swe=%0d expected 1/0", acc_cyc - last_ack_cyc, acc_swe);
        end
        clr_log();
        cpu_access(1'b0, 32'h40);
        checks++;
        if (acc_got !== 1'b1 || acc_lat != 2 || q_beat.size() != 0 || acc_way !== 1'b0) begin
            failures++;
            $display("FAIL hit_latency: got ack=%0d lat=%0d beats=%0d way=%0d expected 1/2/0/0",
                     acc_got, acc_lat, q_beat.size(), acc_way);
        end
    endtask

    task automatic test_store_evict();
        logic [36:0] exp;
        clr_log();
        cpu_access(1'b1, 32'h44);
        checks++;
        if (acc_lat != 2 || {acc_swe, acc_sel, acc_way} !== 3'b100 || q_beat.size() != 0) begin
            failures++;
            $display("FAIL store_hit: got lat=%0d swe/sel/way=%b beats=%0d expected 2/100/0",
                     acc_lat, {acc_swe, acc_sel, acc_way}, q_beat.size());
        end
        clr_log();
        cpu_access(1'b0, 32'h440);
        checks++;
        if (q_beat.size() != 4 || q_beat[0] !== {3'b011, 2'd0, 32'h440} || acc_way !== 1'b1) begin
            failures++;
            $display("FAIL fill_way1: got beats=%0d first=%h way=%0d expected 4/%h/1",
                     q_beat.size(), q_beat[0], acc_way, {3'b011, 2'd0, 32'h440});
        end
        clr_log();
        cpu_access(1'b0, 32'h840);
        checks++;
        if (q_beat.size() != 8 || acc_way !== 1'b0) begin
            failures++;
            $display("FAIL evict_dirty: got beats=%0d way=%0d expected 8/0", q_beat.size(), acc_way);
        end
        for (int b = 0; b < q_beat.size() && b < 8; b++) begin
            exp = (b < 4) ? {3'b100, 2'(b), 32'h40 + 32'(4 * b)}
                          : {3'b011, 2'(b - 4), 32'h840 + 32'(4 * (b - 4))};
            checks++;
            if (q_beat[b] !== exp) begin
                failures++;
                $display("FAIL evict_beat%0d: got %h expected %h", b, q_beat[b], exp);
            end
        end
        clr_log();
        cpu_access(1'b0, 32'hC40);
        checks++;
        if (q_beat.size() != 4 || q_beat[0] !== {3'b011, 2'd0, 32'hC40} || acc_way !== 1'b1) begin
            failures++;
            $display("FAIL rr_advance: got beats=%0d first=%h way=%0d expected 4/%h/1",
                     q_beat.size(), q_beat[0], acc_way, {3'b011, 2'd0, 32'hC40});
        end
    endtask

    task automatic test_store_miss();
        logic [36:0] exp;
        clr_log();
        cpu_access(1'b1, 32'h100);
        checks++;
        if (q_beat.size() != 4 || {acc_swe, acc_sel, acc_way} !== 3'b100) begin
            failures++;
            $display("FAIL store_miss: got beats=%0d swe/sel/way=%b expected 4/100",
                     q_beat.size(), {acc_swe, acc_sel, acc_way});
        end
        for (int b = 0; b < q_beat.size() && b < 4; b++) begin
            exp = {3'b011, 2'(b), 32'h100 + 32'(4 * b)};
            checks++;
            if (q_beat[b] !== exp) begin
                failures++;
                $display("FAIL store_miss_beat%0d: got %h expected %h", b, q_beat[b], exp);
            end
        end
        cpu_access(1'b0, 32'h200);
        clr_log();
        cpu_access(1'b0, 32'h300);
        checks++;
        if (q_beat.size() != 8 || q_beat[0] !== {3'b100, 2'd0, 32'h100}
            || q_beat[4] !== {3'b011, 2'd0, 32'h300}) begin
            failures++;
            $display("FAIL store_miss_wb: got beats=%0d b0=%h b4=%h expected 8/%h/%h", q_beat.size(),
                     q_beat[0], q_beat[4], {3'b100, 2'd0, 32'h100}, {3'b011, 2'd0, 32'h300});
        end
    endtask

    task automatic test_stretched();
        logic [36:0] exp;
        gap = 5;
        clr_log();
        cpu_access(1'b0, 32'h500);
        gap = 0;
        checks++;
        if (acc_got !== 1'b1 || q_beat.size() != 4 || idle_cnt != 20 || idle_bad != 0) begin
            failures++;
            $display("FAIL stretched: got ack=%0d beats=%0d idle=%0d bad=%0d expected 1/4/20/0",
                     acc_got, q_beat.size(), idle_cnt, idle_bad);
        end
        for (int b = 0; b < q_beat.size() && b < 4; b++) begin
            exp = {3'b011, 2'(b), 32'h500 + 32'(4 * b)};
            checks++;
            if (q_beat[b] !== exp) begin
                failures++;
                $display("FAIL stretched_beat%0d: got %h expected %h", b, q_beat[b], exp);
            end
        end
    endtask

`ifdef L1_PERF_CNT_EN
    task automatic test_perf();
        checks++;
        if (bus.perf_hits !== 32'd2 || bus.perf_misses !== 32'd8 || bus.perf_wbacks !== 32'd2) begin
            failures++;
            $display("FAIL perf_counts: got %0d/%0d/%0d expected 2/8/2", bus.perf_hits, bus.perf_misses, bus.perf_wbacks);
        end
    endtask
`endif

    task automatic test_reset_midburst();
        bit seen;
        clr_log();
        ack_budget = 2;
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h600;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (q_beat.size() >= 2) seen = 1;
        end
        @(posedge clk); #2;
        checks++;
        if (q_beat.size() != 2 || bus.dram_cs !== 1'b1) begin
            failures++;
            $display("FAIL midburst_setup: got beats=%0d cs=%0d expected 2/1", q_beat.size(), bus.dram_cs);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.dram_cs, bus.dram_we, bus.sram_we, bus.dram_addr} !== 35'd0) begin
            failures++;
            $display("FAIL midburst_cs_drop: got cs=%0d we=%0d swe=%0d addr=%h expected all 0",
                     bus.dram_cs, bus.dram_we, bus.sram_we, bus.dram_addr);
        end
        bus.cpu_req = 1'b0;
        ack_budget  = -1;
        @(negedge clk);
`ifdef L1_PERF_CNT_EN
        checks++;
        if ({bus.perf_hits, bus.perf_misses, bus.perf_wbacks} !== 96'd0) begin
            failures++;
            $display("FAIL midburst_perf_clear: got %0d/%0d/%0d expected 0", bus.perf_hits, bus.perf_misses, bus.perf_wbacks);
        end
`endif
        rst = 1'b1;
        clr_log();
        cpu_access(1'b0, 32'h600);
        checks++;
        if (q_beat.size() != 4 || q_beat[0] !== {3'b011, 2'd0, 32'h600}) begin
            failures++;
            $display("FAIL midburst_rerefill: got beats=%0d first=%h expected 4/%h",
                     q_beat.size(), q_beat[0], {3'b011, 2'd0, 32'h600});
        end
        clr_log();
        cpu_access(1'b0, 32'hC40);
        checks++;
        if (q_beat.size() != 4) begin
            failures++;
            $display("FAIL midburst_valid_clear: got beats=%0d expected 4", q_beat.size());
        end
        clr_log();
        cpu_access(1'b0, 32'h600);
        checks++;
        if (acc_lat != 2 || q_beat.size() != 0) begin
            failures++;
            $display("FAIL midburst_rehit: got lat=%0d beats=%0d expected 2/0", acc_lat, q_beat.size());
        end
`ifdef L1_PERF_CNT_EN
        checks++;
        if (bus.perf_hits !== 32'd1 || bus.perf_misses !== 32'd2 || bus.perf_wbacks !== 32'd0) begin
            failures++;
            $display("FAIL perf_after_reset: got %0d/%0d/%0d expected 1/2/0", bus.perf_hits, bus.perf_misses, bus.perf_wbacks);
        end
`endif
    endtask

    initial begin
        rst          = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = '0;
        test_reset();
        test_cold_read();
        test_store_evict();
        test_store_miss();
        test_stretched();
`ifdef L1_PERF_CNT_EN
        test_perf();
`endif
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
